// File: rtl/psum_accum_glb.sv
// Partial-sum global buffer: one write port and one synchronous read port.
// Writes either overwrite a word or add to it (read-modify-write). An add can
// saturate or wrap. Hazards are forwarded, reads and accumulates share the read
// port under round-robin arbitration, and a zero-fill FSM clears the array.
module psum_accum_glb #(
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 193600,
  parameter int ADDR          = $clog2(DEPTH),
  parameter bit SATURATE      = 1'b1,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                  core_clk,
  input  logic                  core_rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR-1:0]       wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_accum,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR-1:0]       rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  input  logic                  init_start,
  output logic                  busy,
  output logic                  init_done,
  output logic                  sat_flag
);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  localparam state_t                RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_READY;
  localparam logic [ADDR-1:0]       LAST_ADDR   = ADDR'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] SAT_MAX     = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN     = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t state, state_next;
  logic [ADDR-1:0] init_cnt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mem_q;
  logic                  mem_we;
  logic [ADDR-1:0]       mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [ADDR-1:0]       rd_port_addr;

  // Write pipeline stage S1 plus the forwarded old operand for accumulates.
  logic                  s1_valid, s1_accum, s1_fwd;
  logic [ADDR-1:0]       s1_addr;
  logic [DATA_WIDTH-1:0] s1_data, s1_fwd_val;
  logic [DATA_WIDTH-1:0] s1_old, s1_result;
  logic [DATA_WIDTH:0]   s1_sum;
  logic                  s1_ovf;

  // Read return path: forwarded value and a holding register for rd_data.
  logic                  rd_fwd;
  logic [DATA_WIDTH-1:0] rd_fwd_val, rd_hold;

  logic in_ready, contention, rr_write;
  logic wr_fire, rd_fire, accum_fire;

  // Arbitration: only accumulate writes compete with reads for the read port.
  always_comb begin
    in_ready     = (state == ST_READY);
    contention   = rd_valid && wr_valid && wr_accum;
    wr_ready     = in_ready && !(contention && !rr_write);
    rd_ready     = in_ready && !(contention && rr_write);
    wr_fire      = wr_valid && wr_ready;
    rd_fire      = rd_valid && rd_ready;
    accum_fire   = wr_fire && wr_accum;
    rd_port_addr = accum_fire ? wr_addr : rd_addr;
    busy         = (state == ST_INIT);
  end

  // S1 arithmetic: signed add at DATA_WIDTH+1 bits, then clamp or truncate.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    s1_result = s1_data;
    s1_old    = s1_fwd ? s1_fwd_val : mem_q;
    s1_sum    = {s1_old[DATA_WIDTH-1], s1_old} + {s1_data[DATA_WIDTH-1], s1_data};
    s1_ovf    = s1_accum && (s1_sum[DATA_WIDTH] != s1_sum[DATA_WIDTH-1]);
    if (s1_accum) begin
      if (s1_ovf && SATURATE) s1_result = s1_sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
      else                    s1_result = s1_sum[DATA_WIDTH-1:0];
    end
  end

  // Write port mux: zero-fill owns the port in INIT; a stale S1 there is dropped
  // since the fill overwrites every word anyway.
  always_comb begin
    mem_we    = s1_valid;
    mem_waddr = s1_addr;
    mem_wdata = s1_result;
    if (state == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_cnt;
      mem_wdata = '0;
    end
  end

  // Read data is live in the return cycle and held from the register afterwards.
  always_comb begin
    rd_data = rd_hold;
    if (rd_data_valid) rd_data = rd_fwd ? rd_fwd_val : mem_q;
  end

  // Memory array with read-before-write synchronous read port.
  // NOTE: the array and its output register have no reset so they map onto block RAM.
  always_ff @(posedge core_clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    mem_q <= mem[rd_port_addr];
  end

  // Next-state logic for the INIT/READY controller.
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:  if (init_cnt == LAST_ADDR) state_next = ST_READY;
      ST_READY: if (init_start)            state_next = ST_INIT;
      default:                             state_next = RESET_STATE;
    endcase
  end

  // State register, fill counter, done pulse, round-robin bit and sticky flag.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state     <= RESET_STATE;
      init_cnt  <= '0;
      init_done <= 1'b0;
      rr_write  <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      state     <= state_next;
      init_done <= (state == ST_INIT) && (init_cnt == LAST_ADDR);
      if (state == ST_INIT && init_cnt != LAST_ADDR) init_cnt <= init_cnt + 1'b1;
      else                                           init_cnt <= '0;
      if (in_ready && contention) rr_write <= ~rr_write;
      if (in_ready && init_start)                 sat_flag <= 1'b0;
      else if (in_ready && s1_valid && s1_ovf)    sat_flag <= 1'b1;
    end
  end

  // S1 capture: the old operand comes from S1 itself when the address repeats.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      s1_valid   <= 1'b0;
      s1_accum   <= 1'b0;
      s1_fwd     <= 1'b0;
      s1_addr    <= '0;
      s1_data    <= '0;
      s1_fwd_val <= '0;
    end else begin
      s1_valid <= wr_fire;
      if (wr_fire) begin
        s1_accum   <= wr_accum;
        s1_addr    <= wr_addr;
        s1_data    <= wr_data;
        s1_fwd     <= s1_valid && (s1_addr == wr_addr);
        s1_fwd_val <= s1_result;
      end
    end
  end

  // Read return: forward the committing S1 result when addresses match.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      rd_data_valid <= 1'b0;
      rd_fwd        <= 1'b0;
      rd_fwd_val    <= '0;
      rd_hold       <= '0;
    end else begin
      rd_data_valid <= rd_fire;
      if (rd_data_valid) rd_hold <= rd_data;
      if (rd_fire) begin
        rd_fwd     <= s1_valid && (s1_addr == rd_addr);
        rd_fwd_val <= s1_result;
      end
    end
  end

endmodule

// File: tb/tb_psum_accum_glb.sv
// Directed bench for psum_accum_glb (DATA_WIDTH=16, DEPTH=16). A saturating
// instance and a wrapping instance receive identical stimulus.
module tb_psum_accum_glb;

  logic        core_clk = 1'b0;
  logic        core_rst = 1'b1;
  logic        wr_valid = 1'b0, wr_accum = 1'b0, rd_valid = 1'b0, init_start = 1'b0;
  logic [3:0]  wr_addr = '0, rd_addr = '0;
  logic [15:0] wr_data = '0;

  logic        wr_ready, rd_ready, rd_data_valid, busy, init_done, sat_flag;
  logic [15:0] rd_data;
  logic        wr_ready_w, rd_ready_w, rd_data_valid_w, busy_w, init_done_w, sat_flag_w;
  logic [15:0] rd_data_w;

  int checks = 0;
  int failures = 0;

  always #5 core_clk = ~core_clk;

  psum_accum_glb #(.DATA_WIDTH(16), .DEPTH(16), .SATURATE(1'b1), .INIT_ON_RESET(1'b1)) dut (
    .core_clk(core_clk), .core_rst(core_rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_accum(wr_accum), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .init_start(init_start),
    .busy(busy), .init_done(init_done), .sat_flag(sat_flag)
  );

  psum_accum_glb #(.DATA_WIDTH(16), .DEPTH(16), .SATURATE(1'b0), .INIT_ON_RESET(1'b1)) dut_w (
    .core_clk(core_clk), .core_rst(core_rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready_w), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_accum(wr_accum), .rd_valid(rd_valid), .rd_ready(rd_ready_w), .rd_addr(rd_addr),
    .rd_data(rd_data_w), .rd_data_valid(rd_data_valid_w), .init_start(init_start),
    .busy(busy_w), .init_done(init_done_w), .sat_flag(sat_flag_w)
  );

  // Issue one write and wait (bounded) for acceptance.
  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic acc);
    int n = 0;
    @(negedge core_clk);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_accum = acc;
    #1;
    while (!wr_ready && n < 50) begin @(negedge core_clk); #1; n++; end
    if (!wr_ready) begin
      checks++; failures++;
      $display("FAIL write_timeout addr=%0d ready=%b required=1", a, wr_ready);
    end
    @(posedge core_clk); #1;
    wr_valid = 1'b0; wr_accum = 1'b0;
  endtask

  // Issue one read and return the data of both instances in the return cycle.
  task automatic do_read(input logic [3:0] a, output logic [15:0] d, output logic [15:0] dw);
    int n = 0;
    @(negedge core_clk);
    rd_valid = 1'b1; rd_addr = a;
    #1;
    while (!rd_ready && n < 50) begin @(negedge core_clk); #1; n++; end
    if (!rd_ready) begin
      checks++; failures++;
      $display("FAIL read_timeout addr=%0d ready=%b required=1", a, rd_ready);
    end
    @(posedge core_clk); #1;
    rd_valid = 1'b0;
    @(negedge core_clk);
    checks++;
    if (rd_data_valid !== 1'b1) begin
      failures++;
      $display("FAIL rd_data_valid addr=%0d got=%b exp=1", a, rd_data_valid);
    end
    d = rd_data; dw = rd_data_w;
  endtask

  // Count busy cycles from the current sample point, then check the done pulse.
  task automatic wait_init(input string tag);
    int n = 0;
    while (busy && n < 100) begin n++; @(negedge core_clk); #1; end
    checks++;
    if (n !== 16 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_cycles got=%0d exp=16 busy=%b", tag, n, busy);
    end
    checks++;
    if (init_done !== 1'b1) begin
      failures++;
      $display("FAIL %s_init_done_pulse got=%b exp=1", tag, init_done);
    end
    @(negedge core_clk); #1;
    checks++;
    if (init_done !== 1'b0) begin
      failures++;
      $display("FAIL %s_init_done_width got=%b exp=0", tag, init_done);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [7:0] got;
    got = {wr_ready, rd_ready, rd_data_valid, init_done, sat_flag, sat_flag_w, busy, busy_w};
    checks++;
    if (got !== 8'b0000_0011 || rd_data !== 16'h0000) begin
      failures++;
      $display("FAIL %s_outputs got=%b rd_data=%h exp=00000011 rd_data=0000", tag, got, rd_data);
    end
  endtask

  task automatic check_all_zero(input string tag);
    logic [15:0] d, dw;
    for (int i = 0; i < 16; i++) begin
      do_read(4'(i), d, dw);
      checks++;
      if (d !== 16'h0000) begin
        failures++;
        $display("FAIL %s_zero addr=%0d got=%h exp=0000", tag, i, d);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge core_clk);
    #1;
    check_reset_outputs("reset");
    @(negedge core_clk);
    core_rst = 1'b0;
    #1;
    wait_init("reset");
    check_all_zero("post_init");
  endtask

  task automatic test_accum_chain();
    logic [15:0] d, dw;
    do_write(4'd3, 16'h0012, 1'b0);
    @(negedge core_clk);
    wr_valid = 1'b1; wr_addr = 4'd3; wr_accum = 1'b1; wr_data = 16'h0005;
    @(posedge core_clk); #1;
    wr_data = 16'h0003;
    @(posedge core_clk); #1;
    wr_valid = 1'b0; wr_accum = 1'b0;
    do_read(4'd3, d, dw);
    checks++;
    if (d !== 16'h001A) begin
      failures++;
      $display("FAIL accum_chain got=%h exp=001a", d);
    end
    checks++;
    if (sat_flag !== 1'b0) begin
      failures++;
      $display("FAIL accum_chain_no_sat got=%b exp=0", sat_flag);
    end
  endtask

  task automatic test_saturate();
    logic [15:0] d, dw;
    do_write(4'd5, 16'h7FF0, 1'b0);
    do_write(4'd5, 16'h0020, 1'b1);
    do_read(4'd5, d, dw);
    checks++;
    if (d !== 16'h7FFF || dw !== 16'h8010) begin
      failures++;
      $display("FAIL sat_pos sat=%h exp=7fff wrap=%h exp=8010", d, dw);
    end
    checks++;
    if (sat_flag !== 1'b1 || sat_flag_w !== 1'b1) begin
      failures++;
      $display("FAIL sat_flag sat=%b wrap=%b exp=1 1", sat_flag, sat_flag_w);
    end
    do_write(4'd6, 16'h8000, 1'b0);
    do_write(4'd6, 16'hFFFF, 1'b1);
    do_read(4'd6, d, dw);
    checks++;
    if (d !== 16'h8000 || dw !== 16'h7FFF) begin
      failures++;
      $display("FAIL sat_neg sat=%h exp=8000 wrap=%h exp=7fff", d, dw);
    end
  endtask

  task automatic test_arbitration();
    logic [15:0] d, dw;
    int n_rd = 0, n_wr = 0;
    @(negedge core_clk);
    rd_valid = 1'b1; rd_addr = 4'd0;
    wr_valid = 1'b1; wr_addr = 4'd9; wr_data = 16'h0001; wr_accum = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if ({rd_ready, wr_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL arb_cycle%0d got rd/wr=%b%b exp=%s", i, rd_ready, wr_ready,
                 (i % 2 == 0) ? "10" : "01");
      end
      if (rd_ready) n_rd++;
      if (wr_ready) n_wr++;
      @(negedge core_clk);
    end
    rd_valid = 1'b0; wr_valid = 1'b0; wr_accum = 1'b0;
    checks++;
    if (n_rd !== 4 || n_wr !== 4) begin
      failures++;
      $display("FAIL arb_counts reads=%0d writes=%0d exp=4 4", n_rd, n_wr);
    end
    do_read(4'd9, d, dw);
    checks++;
    if (d !== 16'h0004) begin
      failures++;
      $display("FAIL arb_accum_result got=%h exp=0004", d);
    end
  endtask

  task automatic test_forwarding();
    logic [15:0] d, dw;
    do_write(4'd7, 16'h0100, 1'b0);
    @(negedge core_clk);
    wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 16'h0011; wr_accum = 1'b1;
    @(posedge core_clk); #1;
    wr_valid = 1'b0; wr_accum = 1'b0;
    rd_valid = 1'b1; rd_addr = 4'd7;
    @(posedge core_clk); #1;
    rd_valid = 1'b0;
    @(negedge core_clk);
    checks++;
    if (rd_data_valid !== 1'b1 || rd_data !== 16'h0111) begin
      failures++;
      $display("FAIL fwd_next_edge valid=%b got=%h exp=1 0111", rd_data_valid, rd_data);
    end
    @(negedge core_clk);
    checks++;
    if (rd_data_valid !== 1'b0 || rd_data !== 16'h0111) begin
      failures++;
      $display("FAIL rd_hold valid=%b got=%h exp=0 0111", rd_data_valid, rd_data);
    end
    wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 16'h0055; wr_accum = 1'b0;
    rd_valid = 1'b1; rd_addr = 4'd7;
    @(posedge core_clk); #1;
    wr_valid = 1'b0; rd_valid = 1'b0;
    @(negedge core_clk);
    checks++;
    if (rd_data_valid !== 1'b1 || rd_data !== 16'h0111) begin
      failures++;
      $display("FAIL same_edge_old valid=%b got=%h exp=1 0111", rd_data_valid, rd_data);
    end
    do_read(4'd7, d, dw);
    checks++;
    if (d !== 16'h0055) begin
      failures++;
      $display("FAIL same_edge_after got=%h exp=0055", d);
    end
  endtask

  task automatic test_init_start();
    logic [15:0] d, dw;
    do_write(4'd4, 16'h0033, 1'b0);
    @(negedge core_clk);
    init_start = 1'b1;
    @(posedge core_clk); #1;
    init_start = 1'b0;
    @(negedge core_clk); #1;
    checks++;
    if (busy !== 1'b1 || sat_flag !== 1'b0 || wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL init_start_enter busy=%b sat=%b wr_ready=%b exp=1 0 0", busy, sat_flag, wr_ready);
    end
    wait_init("init_start");
    do_read(4'd4, d, dw);
    checks++;
    if (d !== 16'h0000) begin
      failures++;
      $display("FAIL init_start_zero got=%h exp=0000", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d, dw;
    do_write(4'd2, 16'h7FFF, 1'b0);
    do_read(4'd2, d, dw);
    @(negedge core_clk);
    wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 16'h0001; wr_accum = 1'b1;
    repeat (3) @(posedge core_clk);
    #1;
    checks++;
    if (sat_flag !== 1'b1 || rd_data !== 16'h7FFF) begin
      failures++;
      $display("FAIL pre_reset sat=%b rd_data=%h exp=1 7fff", sat_flag, rd_data);
    end
    core_rst = 1'b1;
    @(negedge core_clk);
    wr_valid = 1'b0; wr_accum = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge core_clk);
    core_rst = 1'b0;
    #1;
    wait_init("mid_reset");
    check_all_zero("mid_reset");
  endtask

  initial begin
    test_reset();
    test_accum_chain();
    test_saturate();
    test_arbitration();
    test_forwarding();
    test_init_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
